uart_rx: RTL

- UART receiver that pairs with the existing transmit block: 8N1, LSB first, idle-high line.
- Samples the asynchronous `uart_rx_i` pin at 16x the baud rate and reassembles bytes.
- Holds each received byte in a one-entry output register with a valid/read handshake.
- Flags framing errors and overruns for the core's MMIO/console logic.

---
 rtl/uart_rx.sv | 137 +++++++++++++
 1 files changed

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 16x oversampled, two-flop input synchronizer, one-entry
// output register with valid/read handshake and sticky framing/overrun flags.
module uart_rx #(
  parameter int CLK_FREQ = 80000000,
  parameter int BAUD     = 115200,
  parameter int OVS      = 16
) (
  input  logic       sys_clk_i,
  input  logic       sys_rst_i,
  input  logic       uart_rx_i,
  input  logic       uart_rd_i,
  input  logic       uart_err_clr_i,
  output logic [7:0] uart_dat_o,
  output logic       uart_valid_o,
  output logic       uart_busy_o,
  output logic       uart_frame_err_o,
  output logic       uart_overrun_o
);

  localparam int TW = $clog2(OVS);
  localparam logic [32:0]   INC  = 33'(BAUD * OVS);
  localparam logic [32:0]   LIM  = 33'(CLK_FREQ);
  localparam logic [TW-1:0] HALF = TW'(OVS / 2 - 1);
  localparam logic [TW-1:0] LAST = TW'(OVS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

  // Handshake: uart_valid_o=1 means uart_dat_o holds an unread byte; a cycle
  // with uart_rd_i=1 and uart_valid_o=1 consumes it at the next edge.
  state_t        state;
  logic [1:0]    sync;
  logic          rx_s;
  logic [31:0]   acc;
  logic [32:0]   nxt;
  logic          tick;
  logic [TW-1:0] tcnt;
  logic [2:0]    bcnt;
  logic [7:0]    shreg;
  logic          done;
  logic          fe_set;

  assign rx_s        = sync[1];
  assign nxt         = {1'b0, acc} + INC;
  assign tick        = (nxt >= LIM);
  assign uart_busy_o = (state != IDLE);
  assign fe_set      = (state == STOP) && tick && (tcnt == LAST) && !rx_s;

  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      sync             <= 2'b11;
      acc              <= '0;
      state            <= IDLE;
      tcnt             <= '0;
      bcnt             <= '0;
      shreg            <= '0;
      done             <= 1'b0;
      uart_dat_o       <= '0;
      uart_valid_o     <= 1'b0;
      uart_frame_err_o <= 1'b0;
      uart_overrun_o   <= 1'b0;
    end else begin
      sync <= {sync[0], uart_rx_i};
      acc  <= tick ? 32'(nxt - LIM) : nxt[31:0];
      done <= 1'b0;

      case (state)
        IDLE: begin
          if (!rx_s) begin
            tcnt  <= '0;
            state <= START;
          end
        end
        START: begin
          if (tick) begin
            if (tcnt == HALF) begin
              if (rx_s) begin
                state <= IDLE;
              end else begin
                tcnt  <= '0;
                bcnt  <= '0;
                state <= DATA;
              end
            end else begin
              tcnt <= tcnt + TW'(1);
            end
          end
        end
        DATA: begin
          if (tick) begin
            if (tcnt == LAST) begin
              // LSB arrives first, so shifting in at the top leaves it in bit 0
              shreg <= {rx_s, shreg[7:1]};
              tcnt  <= '0;
              bcnt  <= bcnt + 3'd1;
              if (bcnt == 3'd7) state <= STOP;
            end else begin
              tcnt <= tcnt + TW'(1);
            end
          end
        end
        STOP: begin
          if (tick) begin
            if (tcnt == LAST) begin
              if (rx_s) begin
                done  <= 1'b1;
                state <= IDLE;
              end else begin
                state <= WAIT_HIGH;
              end
            end else begin
              tcnt <= tcnt + TW'(1);
            end
          end
        end
        WAIT_HIGH: begin
          if (rx_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      if (done) begin
        if (!uart_valid_o || uart_rd_i) begin
          uart_dat_o   <= shreg;
          uart_valid_o <= 1'b1;
        end
      end else if (uart_rd_i && uart_valid_o) begin
        uart_valid_o <= 1'b0;
      end

      // Setting wins over a simultaneous clear
      uart_frame_err_o <= (uart_frame_err_o & ~uart_err_clr_i) | fe_set;
      uart_overrun_o   <= (uart_overrun_o & ~uart_err_clr_i) |
                          (done & uart_valid_o & ~uart_rd_i);
    end
  end

endmodule
